shift_pipe: RTL and testbench

Parametrised, fully pipelined barrel shifter/rotator for the WISC datapath; the successor to the single-cycle 16-bit ALU shifter. It accepts one operation per cycle over a valid/ready handshake and resolves one amount bit per pipeline stage. It supports logical/arithmetic shifts and both rotate directions at any power-of-two width. It sits between the ALU operand muxes and the writeback mux, and carries a caller tag so results can be matched to instructions.

---
 rtl/shift_pipe_pkg.sv | 14 +
 rtl/shift_pipe_stage.sv | 75 +++++++
 rtl/shift_pipe.sv | 121 ++++++++++++
 tb/tb_shift_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared types for the pipelined shifter: operation encoding and the highest legal op.
package shift_pipe_pkg;

   typedef enum logic [2:0] {
      SHIFT_SLL = 3'd0,
      SHIFT_SRL = 3'd1,
      SHIFT_SRA = 3'd2,
      SHIFT_ROR = 3'd3,
      SHIFT_ROL = 3'd4
   } shift_op_e;

   localparam logic [2:0] SHIFT_OP_MAX = 3'd4;

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline slice of shift_pipe: a 2^K shift/rotate level and its register slice.
module shift_stage
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4,
   parameter int AMT_W = 4,
   parameter int K     = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_i,
   input  logic             vld_i,
   input  logic [2:0]       op_i,
   input  logic [AMT_W-1:0] amt_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             vld_o,
   output logic [2:0]       op_o,
   output logic [AMT_W-1:0] amt_o,
   output logic [TAG_W-1:0] tag_o,
   output logic [WIDTH-1:0] data_o,
   output logic [WIDTH-1:0] nxt_o
);

   localparam int S = 1 << K;

   logic             vld_q;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] amt_q;
   logic [TAG_W-1:0] tag_q;
   logic [WIDTH-1:0] data_q, data_d, shf;

   // Reserved encodings fall through to the default and leave the data untouched.
   always_comb begin
      shf = data_i;
      case (op_i)
         SHIFT_SLL: shf = data_i << S;
         SHIFT_SRL: shf = data_i >> S;
         SHIFT_SRA: shf = $unsigned($signed(data_i) >>> S);
         SHIFT_ROR: shf = (data_i >> S) | (data_i << (WIDTH - S));
         SHIFT_ROL: shf = (data_i << S) | (data_i >> (WIDTH - S));
         default:   shf = data_i;
      endcase
   end

   assign data_d = amt_i[K] ? shf : data_i;
   assign nxt_o  = data_d;

   // Payload only moves with a real request; a bubble just clears the valid bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= 1'b0;
         op_q   <= '0;
         amt_q  <= '0;
         tag_q  <= '0;
         data_q <= '0;
      end else if (ld_i) begin
         vld_q <= vld_i;
         if (vld_i) begin
            op_q   <= op_i;
            amt_q  <= amt_i;
            tag_q  <= tag_i;
            data_q <= data_d;
         end
      end
   end

   assign vld_o  = vld_q;
   assign op_o   = op_q;
   assign amt_o  = amt_q;
   assign tag_o  = tag_q;
   assign data_o = data_q;

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator, one amount bit per stage, valid/ready in and out.
// Optional out_zero/out_neg flags are built only when SHIFT_PIPE_FLAGS_EN is defined.
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int TAG_W = 4,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int L = AMT_W;

   // Index k is the input of stage k; index k+1 is its registered output.
   logic [L:0]              vld_w;
   logic [L:0]              rdy;
   logic [L:0][2:0]         op_w;
   logic [L:0][AMT_W-1:0]   amt_w;
   logic [L:0][TAG_W-1:0]   tag_w;
   logic [L:0][WIDTH-1:0]   data_w;
   logic [L-1:0][WIDTH-1:0] nxt_w;

   assign vld_w[0]  = in_valid;
   assign op_w[0]   = in_op;
   assign amt_w[0]  = in_amt;
   assign tag_w[0]  = in_tag;
   assign data_w[0] = in_data;

   // Empty stages always accept, so bubbles collapse even under a stall.
   always_comb begin
      rdy    = '0;
      rdy[L] = out_ready;
      for (int k = L - 1; k >= 0; k--)
         rdy[k] = !vld_w[k+1] || rdy[k+1];
   end

   assign in_ready = rdy[0];

   for (genvar k = 0; k < L; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .TAG_W (TAG_W),
         .AMT_W (AMT_W),
         .K     (k)
      ) u_stage (
         .clk    (clk),
         .rst    (rst),
         .ld_i   (rdy[k]),
         .vld_i  (vld_w[k]),
         .op_i   (op_w[k]),
         .amt_i  (amt_w[k]),
         .tag_i  (tag_w[k]),
         .data_i (data_w[k]),
         .vld_o  (vld_w[k+1]),
         .op_o   (op_w[k+1]),
         .amt_o  (amt_w[k+1]),
         .tag_o  (tag_w[k+1]),
         .data_o (data_w[k+1]),
         .nxt_o  (nxt_w[k])
      );
   end

   // Side outputs load on the same enable as the last stage's payload.
   logic fin_ld;
   logic err_q, err_d;

   assign fin_ld = rdy[L-1] && vld_w[L-1];
   assign err_d  = op_w[L-1] > SHIFT_OP_MAX;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         err_q <= 1'b0;
      else if (fin_ld) err_q <= err_d;
   end

`ifdef SHIFT_PIPE_FLAGS_EN
   logic zero_q, zero_d, neg_q, neg_d;

   assign zero_d = ~|nxt_w[L-1];
   assign neg_d  = nxt_w[L-1][WIDTH-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (fin_ld) begin
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

   logic unused_sig;
   assign unused_sig = ^{nxt_w, amt_w[L], op_w[L]};

   assign out_valid = vld_w[L];
   assign out_data  = data_w[L];
   assign out_tag   = tag_w[L];
   assign out_err   = err_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Directed and randomised checks of shift_pipe at WIDTH=16 (a_*) and WIDTH=32 (b_*).
module tb_shift_pipe;
  import shift_pipe_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              a_iv, a_ir, a_ov, a_ordy, a_oe, a_oz, a_on;
  logic [2:0]        a_iop;
  logic [15:0]       a_id, a_od;
  logic [3:0]        a_ia;
  logic [TAG_W-1:0]  a_it, a_ot;

  logic              b_iv, b_ir, b_ov, b_ordy, b_oe, b_oz, b_on;
  logic [2:0]        b_iop;
  logic [31:0]       b_id, b_od;
  logic [4:0]        b_ia;
  logic [TAG_W-1:0]  b_it, b_ot;

  shift_pipe #(.WIDTH(16), .TAG_W(TAG_W)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_op(a_iop),
    .in_data(a_id), .in_amt(a_ia), .in_tag(a_it), .out_valid(a_ov),
    .out_ready(a_ordy), .out_data(a_od), .out_tag(a_ot), .out_err(a_oe),
    .out_zero(a_oz), .out_neg(a_on));

  shift_pipe #(.WIDTH(32), .TAG_W(TAG_W)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_op(b_iop),
    .in_data(b_id), .in_amt(b_ia), .in_tag(b_it), .out_valid(b_ov),
    .out_ready(b_ordy), .out_data(b_od), .out_tag(b_ot), .out_err(b_oe),
    .out_zero(b_oz), .out_neg(b_on));

  typedef struct {
    logic [63:0]      d;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             z;
    logic             n;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  // One-bit-at-a-time reference, repeated amt times.
  function automatic logic [63:0] ref_shift(input logic [2:0] op, input logic [63:0] d,
                                            input int amt, input int w);
    logic [63:0] r, msk;
    logic msb, lsb;
    msk = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = d & msk;
    for (int i = 0; i < amt; i++) begin
      msb = r[w-1];
      lsb = r[0];
      case (op)
        3'd0: r = r << 1;
        3'd1: r = r >> 1;
        3'd2: r = (r >> 1) | (64'(msb) << (w - 1));
        3'd3: r = (r >> 1) | (64'(lsb) << (w - 1));
        3'd4: r = (r << 1) | 64'(msb);
        default: r = r;
      endcase
      r = r & msk;
    end
    return r;
  endfunction

  task automatic chk_flags(input string nm, input logic oz, input logic on,
                           input logic ez, input logic en);
`ifdef SHIFT_PIPE_FLAGS_EN
    chk({nm, "_zero"}, 64'(oz), 64'(ez));
    chk({nm, "_neg"},  64'(on), 64'(en));
`else
    chk({nm, "_zero"}, 64'(oz), 64'(ez & 1'b0));
    chk({nm, "_neg"},  64'(on), 64'(en & 1'b0));
`endif
  endtask

  // Single request into an empty pipe; result must appear after the 4th edge exactly.
  task automatic single(input string nm, input logic [2:0] op, input logic [15:0] d,
                        input logic [3:0] amt, input logic [3:0] tag, input logic [15:0] ed,
                        input logic ee, input logic ez, input logic en);
    @(negedge clk);
    a_iv = 1'b1; a_iop = op; a_id = d; a_ia = amt; a_it = tag; a_ordy = 1'b1;
    #1 chk({nm, "_in_ready"}, 64'(a_ir), 64'd1);
    for (int e = 1; e < 4; e++) begin
      @(negedge clk);
      a_iv = 1'b0;
      chk({nm, "_early_valid"}, 64'(a_ov), 64'd0);
    end
    @(negedge clk);
    chk({nm, "_valid"}, 64'(a_ov), 64'd1);
    chk({nm, "_data"},  64'(a_od), 64'(ed));
    chk({nm, "_tag"},   64'(a_ot), 64'(tag));
    chk({nm, "_err"},   64'(a_oe), 64'(ee));
    chk_flags(nm, a_oz, a_on, ez, en);
  endtask

  initial begin
    exp_t e;
    logic [63:0] r;
    a_iv = 0; a_iop = 0; a_id = 0; a_ia = 0; a_it = 0; a_ordy = 1;
    b_iv = 0; b_iop = 0; b_id = 0; b_ia = 0; b_it = 0; b_ordy = 1;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_valid", 64'(a_ov), 64'd0);
    chk("rst_data",  64'(a_od), 64'd0);
    chk("rst_tag",   64'(a_ot), 64'd0);
    chk("rst_err",   64'(a_oe), 64'd0);
    chk_flags("rst", a_oz, a_on, 1'b0, 1'b0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 64'(a_ir), 64'd1);

    // Directed vectors
    single("sra15",  SHIFT_SRA, 16'h8000, 4'd15, 4'h1, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    single("sll1",   SHIFT_SLL, 16'h7FFF, 4'd1,  4'h2, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    single("ror1",   SHIFT_ROR, 16'h0001, 4'd1,  4'h3, 16'h8000, 1'b0, 1'b0, 1'b1);
    single("rol4",   SHIFT_ROL, 16'h8001, 4'd4,  4'h4, 16'h0018, 1'b0, 1'b0, 1'b0);
    single("srl15",  SHIFT_SRL, 16'h8000, 4'd15, 4'h5, 16'h0001, 1'b0, 1'b0, 1'b0);
    single("sll0",   SHIFT_SLL, 16'h0001, 4'd0,  4'h6, 16'h0001, 1'b0, 1'b0, 1'b0);
    single("sllz",   SHIFT_SLL, 16'h8000, 4'd1,  4'h7, 16'h0000, 1'b0, 1'b1, 1'b0);
    single("sra3",   SHIFT_SRA, 16'h4000, 4'd3,  4'h8, 16'h0800, 1'b0, 1'b0, 1'b0);
    single("ror8",   SHIFT_ROR, 16'h1234, 4'd8,  4'h9, 16'h3412, 1'b0, 1'b0, 1'b0);
    single("rol4b",  SHIFT_ROL, 16'h1234, 4'd4,  4'hA, 16'h2341, 1'b0, 1'b0, 1'b0);
    single("rsv6",   3'd6,      16'h1234, 4'd3,  4'hB, 16'h1234, 1'b1, 1'b0, 1'b0);

    // Backpressure: fill with out_ready low, then drain in order
    @(negedge clk);
    a_ordy = 1'b0; a_iop = SHIFT_SLL; a_ia = 4'd0;
    for (int k = 0; k < 4; k++) begin
      a_iv = 1'b1; a_it = 4'(k); a_id = 16'(16'h0100 + k);
      #1 chk("bp_in_ready", 64'(a_ir), 64'd1);
      @(negedge clk);
    end
    a_it = 4'd4; a_id = 16'h0104;
    #1;
    chk("bp_full_ready", 64'(a_ir), 64'd0);
    chk("bp_hold_valid", 64'(a_ov), 64'd1);
    chk("bp_hold_tag",   64'(a_ot), 64'd0);
    @(negedge clk);
    chk("bp_hold_tag2",  64'(a_ot), 64'd0);
    chk("bp_hold_data2", 64'(a_od), 64'h0100);
    chk("bp_full_ready2", 64'(a_ir), 64'd0);
    a_ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 2) begin
        a_iv = 1'b1; a_it = 4'(4 + k); a_id = 16'(16'h0104 + k);
      end else a_iv = 1'b0;
      #1;
      chk("bp_drain_valid", 64'(a_ov), 64'd1);
      chk("bp_drain_tag",   64'(a_ot), 64'(k));
      chk("bp_drain_data",  64'(a_od), 64'(16'h0100 + k));
      chk("bp_drain_ready", 64'(a_ir), 64'd1);
      @(negedge clk);
    end
    #1 chk("bp_empty", 64'(a_ov), 64'd0);

    // Reset with requests in flight
    @(negedge clk);
    a_ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_iv = 1'b1; a_iop = SHIFT_SLL; a_ia = 4'd0; a_it = 4'(8 + k); a_id = 16'(16'h0200 + k);
      @(negedge clk);
    end
    a_iv = 1'b0;
    @(negedge clk);
    #1 chk("rstf_pre_valid", 64'(a_ov), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstf_valid", 64'(a_ov), 64'd0);
    chk("rstf_data",  64'(a_od), 64'd0);
    chk("rstf_tag",   64'(a_ot), 64'd0);
    @(negedge clk);
    chk("rstf_valid2", 64'(a_ov), 64'd0);
    a_ordy = 1'b1;
    rst = 1'b0;
    #1;
    chk("rstf_in_ready", 64'(a_ir), 64'd1);
    chk("rstf_valid3",   64'(a_ov), 64'd0);
    single("post_rst", SHIFT_SLL, 16'h00F0, 4'd4, 4'hC, 16'h0F00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_only", 64'(a_ov), 64'd0);
    end

    // Random stress on both widths against the bit-serial model
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c < 640) begin
        a_iv = 1'($urandom_range(0, 1)); a_iop = 3'($urandom_range(0, 7));
        a_id = 16'($urandom); a_ia = 4'($urandom); a_it = 4'($urandom);
        a_ordy = ($urandom_range(0, 3) != 0);
        b_iv = 1'($urandom_range(0, 1)); b_iop = 3'($urandom_range(0, 7));
        b_id = 32'($urandom); b_ia = 5'($urandom); b_it = 4'($urandom);
        b_ordy = ($urandom_range(0, 3) != 0);
      end else begin
        a_iv = 1'b0; a_ordy = 1'b1;
        b_iv = 1'b0; b_ordy = 1'b1;
      end
      #1;
      if (a_iv && a_ir) begin
        r = ref_shift(a_iop, 64'(a_id), int'(a_ia), 16);
        e = '{d: r, tag: a_it, err: (a_iop > 3'd4), z: (r == 64'd0), n: r[15]};
        qa.push_back(e);
      end
      if (b_iv && b_ir) begin
        r = ref_shift(b_iop, 64'(b_id), int'(b_ia), 32);
        e = '{d: r, tag: b_it, err: (b_iop > 3'd4), z: (r == 64'd0), n: r[31]};
        qb.push_back(e);
      end
      if (a_ov && a_ordy) begin
        if (qa.size() == 0) chk("a_spurious", 64'(a_ov), 64'd0);
        else begin
          e = qa.pop_front();
          chk("a_rnd_data", 64'(a_od), e.d);
          chk("a_rnd_tag",  64'(a_ot), 64'(e.tag));
          chk("a_rnd_err",  64'(a_oe), 64'(e.err));
          chk_flags("a_rnd", a_oz, a_on, e.z, e.n);
        end
      end
      if (b_ov && b_ordy) begin
        if (qb.size() == 0) chk("b_spurious", 64'(b_ov), 64'd0);
        else begin
          e = qb.pop_front();
          chk("b_rnd_data", 64'(b_od), e.d);
          chk("b_rnd_tag",  64'(b_ot), 64'(e.tag));
          chk("b_rnd_err",  64'(b_oe), 64'(e.err));
          chk_flags("b_rnd", b_oz, b_on, e.z, e.n);
        end
      end
    end
    chk("a_drained", 64'(qa.size()), 64'd0);
    chk("b_drained", 64'(qb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
